// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- hazard and stall controller for a 5-stage in-order pipeline.
//
// Decides each cycle which pipeline registers load, which get flushed to a
// bubble, and whether a data-memory access is outstanding.  A data access
// that is not completed is waited on (MEM_WAIT).  If it is still incomplete
// after TIMEOUT wait cycles, the controller parks in FAULT until reset.
//
// Parameters
//   TIMEOUT  max MEM_WAIT cycles before fault (1..65535)
//   CNT_W    width of the stall_cycles counter
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   id_rs1, id_rs2            source regs of the instruction in ID
//   ex_memread, ex_rd         load in EX and its destination
//   ex_branch_taken           branch/jump resolved taken in EX
//   mem_access, dmem_ready    MEM-stage access and memory completion
//   dmem_req                  data-memory request
//   pc_en, en_*               PC and pipeline register load enables
//   flush_ifid, flush_idex    bubble-insert controls
//   fault                     sticky memory-timeout indication
//   stall_cycles              saturating count of cycles with pc_en low
module pipeline_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rd,
   input  logic             ex_branch_taken,
   input  logic             mem_access,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             en_ifid,
   output logic             en_idex,
   output logic             en_exmem,
   output logic             en_memwb,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             fault,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } state_t;

   // Control bundle driven out of the combinational decode.
   typedef struct packed {
      logic req;
      logic pc;
      logic ifid;
      logic idex;
      logic exmem;
      logic memwb;
      logic fl_ifid;
      logic fl_idex;
   } ctl_t;

   localparam logic [15:0]      TO      = 16'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t      state;
   logic [15:0] wait_cnt;
   ctl_t        ctl;
   logic        load_use;
   logic        mem_stall;

   // A load in EX whose result is needed by ID; x0 is hardwired so never hazards.
   assign load_use  = ex_memread && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

   // Memory stall freezes everything. In MEM_WAIT the access is still pending
   // regardless of what mem_access shows, so only dmem_ready releases it.
   assign mem_stall = !dmem_ready &&
                      (((state == RUN) && mem_access) || (state == MEM_WAIT));

   always_comb begin
      ctl = '0;
      if (!rst) begin
         case (state)
            RUN, MEM_WAIT: begin
               ctl.req = (state == MEM_WAIT) || mem_access;
               if (!mem_stall) begin
                  ctl.pc    = 1'b1;
                  ctl.ifid  = 1'b1;
                  ctl.idex  = 1'b1;
                  ctl.exmem = 1'b1;
                  ctl.memwb = 1'b1;
                  if (ex_branch_taken) begin
                     // Wrong-path instructions in IF/ID and ID/EX are squashed;
                     // this also drops any load-use stall for that ID instruction.
                     ctl.fl_ifid = 1'b1;
                     ctl.fl_idex = 1'b1;
                  end else if (load_use) begin
                     // Hold PC and IF/ID, send a bubble into EX.
                     ctl.pc      = 1'b0;
                     ctl.ifid    = 1'b0;
                     ctl.fl_idex = 1'b1;
                  end
               end
            end
            default: ctl = '0;  // FAULT: frozen, no request
         endcase
      end
   end

   assign dmem_req   = ctl.req;
   assign pc_en      = ctl.pc;
   assign en_ifid    = ctl.ifid;
   assign en_idex    = ctl.idex;
   assign en_exmem   = ctl.exmem;
   assign en_memwb   = ctl.memwb;
   assign flush_ifid = ctl.fl_ifid;
   assign flush_idex = ctl.fl_idex;

   // Gated by rst so the indication drops in the reset cycle itself.
   assign fault = (state == FAULT) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         wait_cnt     <= 16'd0;
         stall_cycles <= '0;
      end else begin
         if (!pc_en && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + CNT_ONE;

         case (state)
            RUN: begin
               if (mem_access && !dmem_ready) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= 16'd1;
               end
            end
            MEM_WAIT: begin
               // Completion on the timeout cycle still counts as success.
               if (dmem_ready) begin
                  state    <= RUN;
                  wait_cnt <= 16'd0;
               end else if (wait_cnt == TO) begin
                  state <= FAULT;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            FAULT: state <= FAULT;
            default: begin
               state    <= RUN;
               wait_cnt <= 16'd0;
            end
         endcase
      end
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum MEM_WAIT cycles before fault; legal range 1..65535.
REQ-002 Parameter CNT_W, default 32: width of the stall_cycles performance counter.
REQ-003 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 id_rs1, id_rs2  input  5 each  source register indices of the instruction in ID.
REQ-006 ex_memread  input  1  instruction in EX is a load.
REQ-007 ex_rd  input  5  destination register of the instruction in EX.
REQ-008 ex_branch_taken  input  1  branch/jump resolved taken in EX.
REQ-009 mem_access  input  1  instruction in MEM performs a data-memory load or store.
REQ-010 dmem_ready  input  1  data memory completes the current access this cycle.
REQ-011 dmem_req  output  1  data-memory access request.
REQ-012 pc_en, en_ifid, en_idex, en_exmem, en_memwb  output  1 each  load enables for the PC and the four pipeline registers.
REQ-013 flush_ifid, flush_idex  output  1 each  clear IF/ID or ID/EX to a bubble on the next edge.
REQ-014 fault  output  1  sticky data-memory timeout indication.
REQ-015 stall_cycles  output  CNT_W  count of cycles with pc_en low.

Function
REQ-016 FSM states: RUN, MEM_WAIT, FAULT; state register, wait counter (16 bit), and stall_cycles are the only storage.
REQ-017 All outputs except fault and stall_cycles are combinational from state and current inputs.
REQ-018 Baseline (RUN, no hazard): all five enables 1, both flushes 0.
REQ-019 Memory stall: in RUN with mem_access=1 and dmem_ready=0: all enables 0, flushes 0, next state MEM_WAIT, wait counter loaded with 1.
REQ-020 mem_access=1 with dmem_ready=1 in RUN: no stall, state stays RUN.
REQ-021 dmem_req = 1 when (RUN and mem_access) or MEM_WAIT; 0 otherwise.
REQ-022 MEM_WAIT with dmem_ready=0: all enables 0, flushes 0, wait counter increments; when counter equals TIMEOUT, next state FAULT.
REQ-023 MEM_WAIT with dmem_ready=1: pipeline advances this cycle exactly as in RUN (REQ-018, REQ-024..026 apply), next state RUN; dmem_ready on the same cycle the counter reaches TIMEOUT wins (go RUN, no fault).
REQ-024 Load-use hazard: ex_memread=1, ex_rd!=0, ex_rd equal to id_rs1 or id_rs2: pc_en=0, en_ifid=0, flush_idex=1, en_idex/en_exmem/en_memwb=1.
REQ-025 Taken branch: ex_branch_taken=1: flush_ifid=1, flush_idex=1, all enables 1.
REQ-026 Priority: memory stall > taken branch > load-use; a taken branch suppresses load-use stalling in the same cycle.
REQ-027 ex_rd=0 never creates a load-use hazard.
REQ-028 FAULT: all enables 0, flushes 0, dmem_req 0, fault=1; leaves only on rst.
REQ-029 stall_cycles increments by 1 on every edge where pc_en=0 (not during rst); saturates at all-ones.

Reset
REQ-030 While rst=1: state RUN, wait counter 0, fault 0, stall_cycles 0; combinational outputs forced to: all enables 0, flushes 0, dmem_req 0.
REQ-031 rst asserted in MEM_WAIT or FAULT aborts the access; first cycle after rst deasserts behaves as RUN.

Verification
REQ-032 Load-use: ex_memread=1, ex_rd=5, id_rs2=5, no mem_access -> one cycle pc_en=0, en_ifid=0, flush_idex=1; stall_cycles 0->1.
REQ-033 Branch+load-use same cycle: ex_branch_taken=1 plus REQ-032 hazard -> flush_ifid=1, flush_idex=1, pc_en=1; stall_cycles unchanged.
REQ-034 Memory wait: mem_access=1, dmem_ready low 3 cycles then high -> enables 0 for 3 cycles, dmem_req 1 for 4 cycles, enables 1 on 4th, state RUN after; stall_cycles +3.
REQ-035 Timeout: TIMEOUT=4, mem_access=1, dmem_ready held 0 -> FAULT entered after 5 stalled cycles, fault=1 held, dmem_req 0; rst clears fault.
REQ-036 Reset mid-wait: rst pulsed during MEM_WAIT -> outputs forced per REQ-030, next cycle baseline enables with dmem_req following mem_access.
REQ-037 ex_rd=0 with ex_memread=1, id_rs1=0 -> no stall.
